// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: takes one command, runs one bus
// transaction, returns one response, with a watchdog for responders that never answer.
module iomem_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busValid_q, busValid_d;
   logic [31:0]       busAddr_q, busAddr_d;
   logic [31:0]       busWdata_q, busWdata_d;
   logic [3:0]        busWstrb_q, busWstrb_d;
   logic              rspValid_q, rspValid_d;
   logic [31:0]       rspRdata_q, rspRdata_d;
   logic              rspErr_q, rspErr_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busValid_q <= 1'b0;
         busAddr_q  <= '0;
         busWdata_q <= '0;
         busWstrb_q <= '0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busValid_q <= busValid_d;
         busAddr_q  <= busAddr_d;
         busWdata_q <= busWdata_d;
         busWstrb_q <= busWstrb_d;
         rspValid_q <= rspValid_d;
         rspRdata_q <= rspRdata_d;
         rspErr_q   <= rspErr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busValid_d = busValid_q;
      busAddr_d  = busAddr_q;
      busWdata_d = busWdata_q;
      busWstrb_d = busWstrb_q;
      rspValid_d = rspValid_q;
      rspRdata_d = rspRdata_q;
      rspErr_d   = rspErr_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               busAddr_d  = {cmd_addr[31:2], 2'b00};
               busWdata_d = cmd_wdata;
               busWstrb_d = cmd_wstrb;
               busValid_d = 1'b1;
               cnt_d      = '0;
               state_d    = BUS;
            end
         end
         BUS: begin
            // A completion in the same cycle as the watchdog expiry still counts as success.
            if (iomem_ready) begin
               busValid_d = 1'b0;
               rspRdata_d = (busWstrb_q == 4'b0000) ? iomem_rdata : 32'h0;
               rspErr_d   = 1'b0;
               rspValid_d = 1'b1;
               state_d    = RESP;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               busValid_d = 1'b0;
               rspRdata_d = (busWstrb_q == 4'b0000) ? ERR_RDATA : 32'h0;
               rspErr_d   = 1'b1;
               rspValid_d = 1'b1;
               state_d    = RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready   = resetn && (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign iomem_valid = busValid_q;
   assign iomem_addr  = busAddr_q;
   assign iomem_wdata = busWdata_q;
   assign iomem_wstrb = busWstrb_q;
   assign rsp_valid   = rspValid_q;
   assign rsp_rdata   = rspRdata_q;
   assign rsp_err     = rspErr_q;

endmodule
